// File: rtl/mb32_master.sv
// mb32_master: byte/half/word load-store master for a 32-bit word bus, splitting unaligned accesses.
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready handshake; req_we, req_sz, req_sx, req_addr, req_wdata describe the access
//   rsp_valid (1-cycle pulse), rsp_rdata (load result, 0 for stores, held until the next pulse)
//   bus: ai word address, vi write data, we write enable, bmsk lane mask (outputs), vo read data (input)
module mb32_master #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_sz,
  input  logic          req_sx,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic [AW-3:0] ai,
  output logic [31:0]   vi,
  output logic          we,
  output logic [3:0]    bmsk,
  input  logic [31:0]   vo
);
  // WR0 is the store's first bus cycle; the other states name the cycle they occupy.
  typedef enum logic [2:0] {IDLE, RA0, RD0, RA1, RD1, WR0, WR1, RSP} state_t;
  state_t state, state_n;
  logic          st, split, sx;
  logic [1:0]    off, sz;
  logic [AW-3:0] w0, w1;
  logic [3:0]    m_hi;
  logic [31:0]   d_hi, lo, hi_src, lo_src, r, res;
  logic [7:0]    m;
  logic [63:0]   d;
  logic          hs;
  assign hs = req_valid & req_ready;
  assign w0 = req_addr[AW-1:2];
  assign m  = (req_sz == 2'd0 ? 8'h01 : req_sz == 2'd1 ? 8'h03 : 8'h0F) << req_addr[1:0];
  assign d  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  // Unsplit loads finish straight from RD0 with vo as the low word; split loads use the
  // captured low word and take vo as the high word in RD1.
  assign hi_src = state == RD1 ? vo : 32'h0;
  assign lo_src = state == RD1 ? lo : vo;
  assign r      = 32'({hi_src, lo_src} >> {off, 3'b000});
  assign res    = sz == 2'd0 ? {{24{sx & r[7]}}, r[7:0]}
                : sz == 2'd1 ? {{16{sx & r[15]}}, r[15:0]} : r;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hs ? (req_we ? WR0 : RA0) : IDLE;
      RA0:     state_n = RD0;
      RD0:     state_n = split ? RA1 : RSP;
      RA1:     state_n = RD1;
      RD1:     state_n = RSP;
      WR0:     state_n = split ? WR1 : RSP;
      WR1:     state_n = RSP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      ai        <= '0;
      vi        <= 32'h0;
      we        <= 1'b0;
      bmsk      <= 4'h0;
      st        <= 1'b0;
      split     <= 1'b0;
      sx        <= 1'b0;
      off       <= 2'd0;
      sz        <= 2'd0;
      w1        <= '0;
      m_hi      <= 4'h0;
      d_hi      <= 32'h0;
      lo        <= 32'h0;
    end else begin
      state     <= state_n;
      req_ready <= state_n == IDLE;
      rsp_valid <= state_n == RSP;
      we        <= state_n == WR0 || state_n == WR1;
      bmsk      <= state_n == WR0 ? m[3:0] : state_n == WR1 ? m_hi : 4'h0;
      if (hs) begin
        st    <= req_we;
        split <= |m[7:4];
        sx    <= req_sx;
        off   <= req_addr[1:0];
        sz    <= req_sz;
        w1    <= w0 + (AW-2)'(1);
        m_hi  <= m[7:4];
        d_hi  <= d[63:32];
        ai    <= w0;
        if (req_we) vi <= d[31:0];
      end
      if (state_n == RA1) ai <= w1;
      if (state_n == WR1) begin
        ai <= w1;
        vi <= d_hi;
      end
      if (state == RD0) lo <= vo;
      if (state_n == RSP) rsp_rdata <= st ? 32'h0 : res;
    end
  end
endmodule

// File: tb/tb_mb32_master.sv
// tb_mb32_master: directed vector bench for mb32_master against a 32K-word single-port RAM model.
module tb_mb32_master;
  logic        clk = 1'b0, rst = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_sx = 1'b0;
  logic [1:0]  req_sz = 2'd0;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, we;
  logic [31:0] rsp_rdata, vi, vo;
  logic [14:0] ai;
  logic [3:0]  bmsk;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mb32_master #(.AW(17)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sz(req_sz), .req_sx(req_sx), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ai(ai), .vi(vi), .we(we), .bmsk(bmsk), .vo(vo)
  );
  logic [31:0] mem [0:32767];
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] mk);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = mk[i] ? nw[8*i +: 8] : old[8*i +: 8];
  endfunction
  always @(posedge clk) begin
    if (we) mem[ai] <= merge(mem[ai], vi, bmsk);
    vo <= mem[ai];
  end
  logic [14:0] tr_ai [1:8];
  logic        tr_we [1:8];
  logic [3:0]  tr_bmsk [1:8];
  logic [31:0] tr_vi [1:8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", n, act, exp);
    end
  endtask
  task automatic run(input logic w, input logic [1:0] s, input logic x, input logic [16:0] a,
                     input logic [31:0] d, output int lat, output logic [31:0] rd);
    logic [31:0] held;
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = w; req_sz = s; req_sx = x; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'hDEAD_BEEF; req_addr = 17'h1ABCD;
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      tr_ai[c] = ai; tr_we[c] = we; tr_bmsk[c] = bmsk; tr_vi[c] = vi;
      chk("we_vs_bmsk", {31'b0, we}, {31'b0, bmsk != 4'h0});
      if (rsp_valid) lat = c;
    end
    if (lat == 0) chk("rsp_timeout", 32'd0, 32'd1);
    rd = rsp_rdata;
    held = rsp_rdata;
    chk("ready_in_rsp", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rsp_pulse", {31'b0, rsp_valid}, 32'd0);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("rdata_hold", rsp_rdata, held);
  endtask
  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [16:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    int          lat;
    logic [14:0] ai0;
  } vec_t;
  vec_t v [22];
  initial begin
    int lat, nwr;
    logic [31:0] rd;
    bit seen;
    v[0]  = '{1'b1, 2'd2, 1'b0, 17'h00100, 32'h11223344, 32'h00000000, 2, 15'h0040};
    v[1]  = '{1'b0, 2'd0, 1'b0, 17'h00101, 32'h0,        32'h00000033, 3, 15'h0040};
    v[2]  = '{1'b0, 2'd1, 1'b1, 17'h00102, 32'h0,        32'h00001122, 3, 15'h0040};
    v[3]  = '{1'b1, 2'd2, 1'b0, 17'h00104, 32'h00000080, 32'h00000000, 2, 15'h0041};
    v[4]  = '{1'b0, 2'd0, 1'b1, 17'h00104, 32'h0,        32'hFFFFFF80, 3, 15'h0041};
    v[5]  = '{1'b0, 2'd0, 1'b0, 17'h00104, 32'h0,        32'h00000080, 3, 15'h0041};
    v[6]  = '{1'b0, 2'd2, 1'b0, 17'h00101, 32'h0,        32'h80112233, 5, 15'h0040};
    v[7]  = '{1'b1, 2'd1, 1'b0, 17'h00203, 32'h0000BEEF, 32'h00000000, 3, 15'h0080};
    v[8]  = '{1'b0, 2'd1, 1'b1, 17'h00203, 32'h0,        32'hFFFFBEEF, 5, 15'h0080};
    v[9]  = '{1'b0, 2'd1, 1'b0, 17'h00203, 32'h0,        32'h0000BEEF, 5, 15'h0080};
    v[10] = '{1'b0, 2'd0, 1'b1, 17'h00204, 32'h0,        32'hFFFFFFBE, 3, 15'h0081};
    v[11] = '{1'b1, 2'd2, 1'b0, 17'h00000, 32'hFFFFFFFF, 32'h00000000, 2, 15'h0000};
    v[12] = '{1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'hA5A5A5A5, 32'h00000000, 3, 15'h7FFF};
    v[13] = '{1'b0, 2'd2, 1'b1, 17'h1FFFE, 32'h0,        32'hA5A5A5A5, 5, 15'h7FFF};
    v[14] = '{1'b0, 2'd2, 1'b0, 17'h00000, 32'h0,        32'hFFFFA5A5, 3, 15'h0000};
    v[15] = '{1'b1, 2'd2, 1'b0, 17'h0FFFC, 32'h01020304, 32'h00000000, 2, 15'h3FFF};
    v[16] = '{1'b1, 2'd2, 1'b0, 17'h10000, 32'h05060708, 32'h00000000, 2, 15'h4000};
    v[17] = '{1'b0, 2'd2, 1'b0, 17'h0FFFE, 32'h0,        32'h07080102, 5, 15'h3FFF};
    v[18] = '{1'b0, 2'd3, 1'b1, 17'h10000, 32'h0,        32'h05060708, 3, 15'h4000};
    v[19] = '{1'b0, 2'd1, 1'b1, 17'h0FFFF, 32'h0,        32'h00000801, 5, 15'h3FFF};
    v[20] = '{1'b1, 2'd0, 1'b0, 17'h00105, 32'hFFFFFF7F, 32'h00000000, 2, 15'h0041};
    v[21] = '{1'b0, 2'd1, 1'b1, 17'h00104, 32'h0,        32'h00007F80, 3, 15'h0041};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_bus", {ai, we, bmsk, 12'b0}, 32'd0);
    chk("rst_vi", vi, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 22; k++) begin
      run(v[k].w, v[k].sz, v[k].sx, v[k].a, v[k].d, lat, rd);
      chk($sformatf("v%0d_rdata", k), rd, v[k].exp);
      chk($sformatf("v%0d_lat", k), lat, v[k].lat);
      chk($sformatf("v%0d_ai0", k), {17'b0, tr_ai[1]}, {17'b0, v[k].ai0});
      nwr = 0;
      for (int c = 1; c <= lat; c++) nwr += int'(tr_we[c]);
      chk($sformatf("v%0d_nwr", k), nwr, v[k].w ? v[k].lat - 1 : 0);
      if (!v[k].w) chk($sformatf("v%0d_ai_hold0", k), {17'b0, tr_ai[2]}, {17'b0, tr_ai[1]});
      if (!v[k].w && v[k].lat == 5) chk($sformatf("v%0d_ai_hold1", k), {17'b0, tr_ai[4]}, {17'b0, tr_ai[3]});
    end
    run(1'b1, 2'd1, 1'b0, 17'h00203, 32'h0000BEEF, lat, rd);
    chk("beef_lat", lat, 3);
    chk("beef_c1", {tr_we[1], 3'b0, tr_bmsk[1], 9'b0, tr_ai[1]}, {1'b1, 3'b0, 4'b1000, 9'b0, 15'h0080});
    chk("beef_c1_lane3", {24'b0, tr_vi[1][31:24]}, 32'h000000EF);
    chk("beef_c2", {tr_we[2], 3'b0, tr_bmsk[2], 9'b0, tr_ai[2]}, {1'b1, 3'b0, 4'b0001, 9'b0, 15'h0081});
    chk("beef_c2_lane0", {24'b0, tr_vi[2][7:0]}, 32'h000000BE);
    chk("beef_c3_idle_bus", {31'b0, tr_we[3]}, 32'd0);
    run(1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'hA5A5A5A5, lat, rd);
    chk("wrap_c1", {tr_bmsk[1], 13'b0, tr_ai[1]}, {4'b1100, 13'b0, 15'h7FFF});
    chk("wrap_c2", {tr_bmsk[2], 13'b0, tr_ai[2]}, {4'b0011, 13'b0, 15'h0000});
    chk("wrap_vi", {tr_vi[1][31:16], tr_vi[2][15:0]}, 32'hA5A5A5A5);
    run(1'b0, 2'd2, 1'b0, 17'h0FFFE, 32'h0, lat, rd);
    chk("bank_rdata", rd, 32'h07080102);
    chk("bank_ai", {1'b0, tr_ai[1], 1'b0, tr_ai[2]}, {16'h3FFF, 16'h3FFF});
    chk("bank_ai_hi", {1'b0, tr_ai[3], 1'b0, tr_ai[4]}, {16'h4000, 16'h4000});
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_sz = 2'd2; req_sx = 1'b0; req_addr = 17'h00100;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_rd0_ai", {17'b0, ai}, 32'h00000040);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    chk("abort_bus", {ai, we, bmsk, 12'b0}, 32'd0);
    chk("abort_vi", vi, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("abort_ready_after", {31'b0, req_ready}, 32'd1);
      seen |= rsp_valid;
    end
    chk("abort_no_rsp", {31'b0, seen}, 32'd0);
    run(1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, lat, rd);
    chk("post_abort_rdata", rd, 32'h11223344);
    chk("post_abort_lat", lat, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
